spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
// - Parametrised SPI slave front-end for the single-port RAM subsystem; successor to the fixed 10-bit SPI slave.
// - Deserialises MOSI into {cmd[1:0], payload[DATA_W-1:0]} words and pulses rx_valid.
// - Serialises RAM read data (tx_data) onto MISO after a read-data command.
// - Adds over the fixed version: width/bit-order parameters, tx_ready handshake, frame-abort error flag.
// PARAMETERS
// - DATA_W     8  payload width; frame = 2 + DATA_W bits after the mode bit
// - LSB_FIRST  0  0: MSB-first shift in/out; 1: LSB-first
// PORTS
// - clk        in   1         single clock; MOSI sampled, MISO launched on rising edge
// - rst        in   1         asynchronous, active-high reset
// - SS_n       in   1         slave select, active low
// - MOSI       in   1         serial data in
// - MISO       out  1         serial data out
// - rx_data    out  DATA_W+2  assembled word {cmd, payload}
// - rx_valid   out  1         one-cycle pulse, rx_data valid
// - tx_data    in   DATA_W    read data from RAM
// - tx_valid   in   1         tx_data valid
// - tx_ready   out  1         slave is waiting for tx_data
// - frame_err  out  1         one-cycle pulse, SS_n rose mid-frame
// BEHAVIOUR
// - Reset: MISO=0, rx_data=0, rx_valid=0, tx_ready=0, frame_err=0, state=IDLE, rd_addr_done=0.
// - States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
// - IDLE: SS_n=0 sampled -> CHK_CMD.
// - CHK_CMD: MOSI=0 -> WRITE.
// - CHK_CMD: MOSI=1 with rd_addr_done=0 -> READ_ADD.
// - CHK_CMD: MOSI=1 with rd_addr_done=1 -> READ_DATA.
// - WRITE/READ_ADD/READ_DATA: shift one MOSI bit per clk into a (DATA_W+2)-bit register.
// - Bit counter counts 0..DATA_W+1.
// - Cycle after the last bit: rx_data=word, rx_valid=1 for exactly one cycle.
// - rx_data holds its value until the next completed frame.
// - Bit order: LSB_FIRST=0 -> first bit lands in rx_data[DATA_W+1]; LSB_FIRST=1 -> first bit lands in rx_data[0].
// - WRITE / READ_ADD after rx_valid: idle in state until SS_n=1, then -> IDLE.
// - READ_ADD: rd_addr_done set to 1 on rx_valid.
// - READ_DATA after rx_valid: tx_ready=1 until tx_valid is sampled high.
// - On tx_valid sample: latch tx_data, drop tx_ready.
// - Next DATA_W cycles: drive MISO with latched bits (MSB first unless LSB_FIRST).
// - Then MISO=0; clear rd_addr_done; wait for SS_n=1 -> IDLE.
// - tx_valid outside the tx_ready window: ignored.
// - tx_valid held high during serialisation: no re-latch.
// - SS_n=1 in any non-IDLE state -> IDLE next cycle.
// - SS_n=1 before rx_valid or before the last MISO bit: frame_err pulses 1 cycle.
// - On frame abort: no rx_valid, rd_addr_done unchanged, MISO=0, tx_ready=0.
// - SS_n=1 in CHK_CMD: IDLE, no frame_err.
// - SS_n low->high->low back-to-back: the IDLE cycle is mandatory; the mode bit is sampled in CHK_CMD.
// - rst asserted mid-frame: all outputs to reset values immediately.
// - rx_data is not qualified by cmd; the RAM decodes cmd.
// STRUCTURE
// - Package spi_pkg holds:
//   - state_e enum
//   - CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
//   - function frame_len(DATA_W) = DATA_W+2
// - Sub-module spi_shifter #(W, LSB_FIRST): SIPO load + PISO shift, bit counter, done flag.
// - Instantiated once; reused for the rx and tx directions.
// - FSM, rd_addr_done, handshake and error logic live in the top.
// TESTING (DATA_W=8 unless noted)
// - Reset: rst=1 mid-frame -> MISO=0, rx_valid=0, rx_data=0, tx_ready=0 within the same cycle.
// - Write: SS_n=0, mode 0, shift 10'b00_1010_0101 -> one rx_valid pulse; rx_data=10'h0A5; SS_n=1 -> IDLE.
// - Read pair, part 1: mode 1, shift 10'h2C3 (cmd 10) -> rx_valid, rx_data=10'h2C3.
// - Read pair, part 2: second frame, mode 1, shift 10'h3FF -> tx_ready=1.
// - Read pair, part 3: tx_data=8'hB6, tx_valid=1 -> MISO 1,0,1,1,0,1,1,0 over 8 cycles; rd_addr_done cleared.
// - Abort: SS_n=1 after 5 of 10 bits -> frame_err pulse, no rx_valid, rx_data keeps previous value, next frame correct.
// - LSB_FIRST=1, DATA_W=16: write frame 18'h2_1234 -> rx_data=18'h2_1234.
// - LSB_FIRST=1, DATA_W=16: read tx_data=16'h8001 -> MISO 1, fourteen 0s, 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave.
// Frame = mode bit, then {cmd[1:0], payload[DATA_W-1:0]}.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic int frame_len(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// Serial pins plus RAM-side handshake of the SPI slave.
// master = SPI master / RAM side, slave = the SPI front-end.
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              frame_err;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, tx_ready, frame_err
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, tx_ready, frame_err
    );
endinterface

// File: rtl/spi_shifter.sv
// Shared SIPO/PISO shift register with bit counter and done flag.
// Used for the rx word first, then reloaded for tx read data.
module spi_shifter #(
    parameter int W         = 10,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CW        = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  par_in,
    input  logic          shift_en,
    input  logic          sin,
    input  logic [CW-1:0] last_idx,
    output logic          sout,
    output logic [W-1:0]  nxt,
    output logic          fin,
    output logic          done
);
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    assign nxt  = LSB_FIRST ? {sin, sr[W-1:1]} : {sr[W-2:0], sin};
    assign sout = LSB_FIRST ? sr[0] : sr[W-1];
    assign fin  = shift_en && (cnt == last_idx);

    // Clear/load/shift with counter; done latches on the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            sr   <= par_in;
            cnt  <= '0;
            done <= 1'b0;
        end else if (shift_en) begin
            sr  <= nxt;
            cnt <= cnt + 1'b1;
            if (fin) done <= 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the single-port RAM.
// FSM, read-address tracking, tx handshake and abort detection.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic clk,
    input logic rst,
    spi_slave_param_if.slave bus
);
    localparam int FL = frame_len(DATA_W);
    localparam int CW = $clog2(FL + 1);

    state_e state, state_nxt;

    logic          rd_addr_done, tx_phase;
    logic [FL-1:0] rx_data_q;
    logic          rx_valid_q, tx_ready_q, frame_err_q;

    logic          data_st, clr, rx_busy, tx_act;
    logic          sh_en, sh_load, sh_fin, sh_done, sh_sout;
    logic          rx_fin, tx_fin, complete;
    logic [FL-1:0] sh_nxt, sh_par;
    logic [CW-1:0] sh_last;

    spi_shifter #(.W(FL), .LSB_FIRST(LSB_FIRST)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (sh_load),
        .par_in   (sh_par),
        .shift_en (sh_en),
        .sin      (bus.MOSI),
        .last_idx (sh_last),
        .sout     (sh_sout),
        .nxt      (sh_nxt),
        .fin      (sh_fin),
        .done     (sh_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; SS_n high always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (!bus.SS_n) state_nxt = CHK_CMD;
            CHK_CMD:
                if (bus.SS_n)         state_nxt = IDLE;
                else if (!bus.MOSI)   state_nxt = WRITE;
                else if (rd_addr_done) state_nxt = READ_DATA;
                else                  state_nxt = READ_ADD;
            default:
                if (bus.SS_n) state_nxt = IDLE;
        endcase
    end

    // Phase decode and shifter control.
    always_comb begin
        data_st  = state inside {WRITE, READ_ADD, READ_DATA};
        clr      = !data_st;
        rx_busy  = data_st && !sh_done && !tx_phase;
        tx_act   = tx_phase && !sh_done;
        sh_load  = (state == READ_DATA) && tx_ready_q
                   && bus.tx_valid && !bus.SS_n;
        sh_en    = (rx_busy || tx_act) && !bus.SS_n;
        sh_last  = tx_phase ? CW'(DATA_W - 1) : CW'(FL - 1);
        rx_fin   = sh_fin && !tx_phase;
        tx_fin   = sh_fin && tx_phase;
        complete = sh_done && ((state != READ_DATA) || tx_phase);
        sh_par   = LSB_FIRST ? {2'b00, bus.tx_data}
                             : {bus.tx_data, 2'b00};
    end

    // Registered outputs, read-address flag and tx handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_ready_q   <= 1'b0;
            tx_phase     <= 1'b0;
        end else begin
            rx_valid_q  <= rx_fin;
            frame_err_q <= data_st && bus.SS_n && !complete;
            if (rx_fin) rx_data_q <= sh_nxt;
            if (rx_fin && state == READ_ADD) rd_addr_done <= 1'b1;
            else if (tx_fin)                 rd_addr_done <= 1'b0;
            if (state != READ_DATA || bus.SS_n) begin
                tx_ready_q <= 1'b0;
                tx_phase   <= 1'b0;
            end else if (rx_fin) begin
                tx_ready_q <= 1'b1;
            end else if (sh_load) begin
                tx_ready_q <= 1'b0;
                tx_phase   <= 1'b1;
            end
        end
    end

    assign bus.MISO      = tx_act & sh_sout;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_ready  = tx_ready_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: 8-bit MSB-first slave and 16-bit LSB-first slave.
// Inputs change on negedge, outputs checked on the next negedge.
`timescale 1ns/1ps
module tb_spi_slave_param;
    import spi_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        ss_a  = 1'b1;
    logic        ss_b  = 1'b1;
    logic        mosi  = 1'b0;
    logic [7:0]  txd_a = '0;
    logic        txv_a = 1'b0;
    logic [15:0] txd_b = '0;
    logic        txv_b = 1'b0;
    logic [7:0]  exp8;
    logic [15:0] exp16;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8))  ia ();
    spi_slave_param_if #(.DATA_W(16)) ib ();

    assign ia.SS_n     = ss_a;
    assign ia.MOSI     = mosi;
    assign ia.tx_data  = txd_a;
    assign ia.tx_valid = txv_a;
    assign ib.SS_n     = ss_b;
    assign ib.MOSI     = mosi;
    assign ib.tx_data  = txd_b;
    assign ib.tx_valid = txv_b;

    spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    spi_slave_param #(.DATA_W(16), .LSB_FIRST(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Select, mode bit, n data bits; returns when rx_valid should show.
    task automatic frame(input bit b, input bit mode, input int n,
                         input logic [17:0] w, input bit lsb);
        @(negedge clk);
        if (b) ss_b = 1'b0; else ss_a = 1'b0;
        @(negedge clk);
        mosi = mode;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mosi = lsb ? w[i] : w[n-1-i];
        end
        @(negedge clk);
    endtask

    task automatic release_ss(input bit b);
        if (b) ss_b = 1'b1; else ss_a = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_miso", ia.MISO, 0);
        chk("rst_rx_data", ia.rx_data, 0);
        chk("rst_rx_valid", ia.rx_valid, 0);
        chk("rst_tx_ready", ia.tx_ready, 0);
        chk("rst_frame_err", ia.frame_err, 0);
        chk("rst_b_rx_data", ib.rx_data, 0);

        frame(0, 1'b0, 10, {CMD_WR_ADDR, 8'hA5}, 0);
        chk("wr_valid", ia.rx_valid, 1);
        chk("wr_data", ia.rx_data, 10'h0A5);
        @(negedge clk);
        chk("wr_pulse_end", ia.rx_valid, 0);
        release_ss(0);
        chk("wr_no_err", ia.frame_err, 0);

        frame(0, 1'b1, 10, {CMD_RD_ADDR, 8'hC3}, 0);
        chk("ra_valid", ia.rx_valid, 1);
        chk("ra_data", ia.rx_data, 10'h2C3);
        chk("ra_no_ready", ia.tx_ready, 0);
        release_ss(0);

        frame(0, 1'b1, 10, {CMD_RD_DATA, 8'hFF}, 0);
        chk("rd_valid", ia.rx_valid, 1);
        chk("rd_data", ia.rx_data, 10'h3FF);
        chk("rd_ready", ia.tx_ready, 1);
        @(negedge clk);
        chk("rd_ready_hold", ia.tx_ready, 1);
        chk("rd_miso_wait", ia.MISO, 0);
        txd_a = 8'hB6;
        txv_a = 1'b1;
        @(negedge clk);
        chk("rd_ready_drop", ia.tx_ready, 0);
        txd_a = 8'h00;
        exp8 = 8'hB6;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("miso_a%0d", k), ia.MISO, exp8[7-k]);
            @(negedge clk);
        end
        chk("miso_a_tail", ia.MISO, 0);
        chk("tx_valid_ignored", ia.tx_ready, 0);
        txv_a = 1'b0;
        release_ss(0);
        chk("rd_no_err", ia.frame_err, 0);

        frame(0, 1'b1, 10, {CMD_RD_ADDR, 8'hAA}, 0);
        chk("ra2_data", ia.rx_data, 10'h2AA);
        chk("addr_cleared", ia.tx_ready, 0);
        @(negedge clk);
        chk("addr_cleared_1", ia.tx_ready, 0);
        release_ss(0);

        @(negedge clk);
        ss_a = 1'b0;
        @(negedge clk);
        mosi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mosi = i[0];
        end
        @(negedge clk);
        ss_a = 1'b1;
        @(negedge clk);
        chk("abort_err", ia.frame_err, 1);
        chk("abort_no_valid", ia.rx_valid, 0);
        chk("abort_keep_data", ia.rx_data, 10'h2AA);
        @(negedge clk);
        chk("abort_err_pulse", ia.frame_err, 0);

        frame(0, 1'b0, 10, {CMD_WR_DATA, 8'h5A}, 0);
        chk("post_abort_valid", ia.rx_valid, 1);
        chk("post_abort_data", ia.rx_data, 10'h15A);
        release_ss(0);

        frame(0, 1'b1, 10, {CMD_RD_DATA, 8'h3C}, 0);
        chk("addr_kept", ia.tx_ready, 1);
        release_ss(0);
        chk("ready_abort_err", ia.frame_err, 1);
        chk("ready_abort_rdy", ia.tx_ready, 0);

        @(negedge clk);
        ss_a = 1'b0;
        @(negedge clk);
        ss_a = 1'b1;
        @(negedge clk);
        chk("chk_cmd_exit", ia.frame_err, 0);

        frame(0, 1'b1, 10, {CMD_RD_DATA, 8'h01}, 0);
        chk("pre_rst_ready", ia.tx_ready, 1);
        txd_a = 8'hFF;
        txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        chk("pre_rst_miso", ia.MISO, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_miso", ia.MISO, 0);
        chk("rst_mid_rx_data", ia.rx_data, 0);
        chk("rst_mid_tx_ready", ia.tx_ready, 0);
        chk("rst_mid_rx_valid", ia.rx_valid, 0);
        ss_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        frame(1, 1'b0, 18, 18'h2_1234, 1);
        chk("b_wr_valid", ib.rx_valid, 1);
        chk("b_wr_data", ib.rx_data, 18'h2_1234);
        release_ss(1);

        frame(1, 1'b1, 18, 18'h2_00AB, 1);
        chk("b_ra_data", ib.rx_data, 18'h2_00AB);
        release_ss(1);

        frame(1, 1'b1, 18, 18'h3_0000, 1);
        chk("b_rd_ready", ib.tx_ready, 1);
        txd_b = 16'h8001;
        txv_b = 1'b1;
        @(negedge clk);
        txv_b = 1'b0;
        chk("b_ready_drop", ib.tx_ready, 0);
        exp16 = 16'h8001;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("miso_b%0d", k), ib.MISO, exp16[k]);
            @(negedge clk);
        end
        chk("miso_b_tail", ib.MISO, 0);
        release_ss(1);
        chk("b_no_err", ib.frame_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
